// File: rtl/sprite_motion_ctrl.sv
// Frame-locked sprite anchor generator: manual push-button or bouncing auto motion.
// Optional macro SPRITE_WRAP_AROUND_EN makes MANUAL moves wrap at the screen edges.
module sprite_motion_ctrl #(
  parameter int unsigned SCREEN_W        = 96,
  parameter int unsigned SCREEN_H        = 64,
  parameter int unsigned SPRITE_W        = 21,
  parameter int unsigned SPRITE_H        = 18,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned INIT_X          = 37,
  parameter int unsigned INIT_Y          = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_begin,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  output logic [6:0] leftX,
  output logic [5:0] topY,
  output logic       auto_mode,
  output logic       hit_edge
);

  localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [6:0] XMAX = 7'(SCREEN_W - SPRITE_W);
  localparam logic [6:0] YMAX = 7'(SCREEN_H - SPRITE_H);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic             dir_x_q, dir_x_d;
  logic             dir_y_q, dir_y_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             btnc_prev_q, btnc_prev_d;
  logic             hit_edge_q, hit_edge_d;

  logic       c_rise;
  logic       step;
  logic [7:0] man_x, man_y;
  logic [8:0] aut_x, aut_y;

  // Returns {hit, next_pos}; opposing requests are resolved by the caller.
  function automatic logic [7:0] manual_axis(input logic [6:0] pos, input logic [6:0] max,
                                             input logic inc, input logic dec);
    logic       hit;
    logic [6:0] nxt;
    hit = 1'b0;
    nxt = pos;
    if (inc) begin
      if (pos >= max) begin
        hit = 1'b1;
`ifdef SPRITE_WRAP_AROUND_EN
        nxt = '0;
`endif
      end else begin
        nxt = pos + 7'd1;
      end
    end else if (dec) begin
      if (pos == 7'd0) begin
        hit = 1'b1;
`ifdef SPRITE_WRAP_AROUND_EN
        nxt = max;
`endif
      end else begin
        nxt = pos - 7'd1;
      end
    end
    return {hit, nxt};
  endfunction

  // Returns {hit, next_dir, next_pos}; dir 1 means +1.
  function automatic logic [8:0] auto_axis(input logic [6:0] pos, input logic [6:0] max,
                                           input logic dir);
    logic       hit;
    logic       nd;
    logic [6:0] nxt;
    hit = 1'b0;
    nd  = dir;
    if (dir) begin
      if (pos >= max) begin
        hit = 1'b1;
        nd  = 1'b0;
        nxt = pos - 7'd1;
      end else begin
        nxt = pos + 7'd1;
      end
    end else begin
      if (pos == 7'd0) begin
        hit = 1'b1;
        nd  = 1'b1;
        nxt = pos + 7'd1;
      end else begin
        nxt = pos - 7'd1;
      end
    end
    return {hit, nd, nxt};
  endfunction

  assign man_x = manual_axis(x_q, XMAX, btnR & ~btnL, btnL & ~btnR);
  assign man_y = manual_axis({1'b0, y_q}, YMAX, btnD & ~btnU, btnU & ~btnD);
  assign aut_x = auto_axis(x_q, XMAX, dir_x_q);
  assign aut_y = auto_axis({1'b0, y_q}, YMAX, dir_y_q);

  assign c_rise = btnC & ~btnc_prev_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    frame_cnt_d = frame_cnt_q;
    btnc_prev_d = btnC;
    hit_edge_d  = 1'b0;
    step        = 1'b0;

    // A mode toggle suppresses any step that lands on the same edge.
    if (c_rise) begin
      state_d     = (state_q == MANUAL) ? AUTO : MANUAL;
      frame_cnt_d = '0;
      if (state_q == MANUAL) begin
        dir_x_d = 1'b1;
        dir_y_d = 1'b1;
      end
    end else if (frame_begin) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        step        = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (step) begin
      if (state_q == MANUAL) begin
        x_d        = man_x[6:0];
        y_d        = man_y[5:0];
        hit_edge_d = man_x[7] | man_y[7];
      end else begin
        x_d        = aut_x[6:0];
        y_d        = aut_y[5:0];
        dir_x_d    = aut_x[7];
        dir_y_d    = aut_y[7];
        hit_edge_d = aut_x[8] | aut_y[8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MANUAL;
      x_q         <= 7'(INIT_X);
      y_q         <= 6'(INIT_Y);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      frame_cnt_q <= '0;
      btnc_prev_q <= 1'b0;
      hit_edge_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      frame_cnt_q <= frame_cnt_d;
      btnc_prev_q <= btnc_prev_d;
      hit_edge_q  <= hit_edge_d;
    end
  end

  assign leftX     = x_q;
  assign topY      = y_q;
  assign auto_mode = (state_q == AUTO);
  assign hit_edge  = hit_edge_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: directed table, corner sequences, random vs. model.
module tb_sprite_motion_ctrl;

  localparam int XMAX = 75;
  localparam int YMAX = 46;
  localparam int FPS  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_begin = 1'b0;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic [6:0] leftX;
  logic [5:0] topY;
  logic       auto_mode;
  logic       hit_edge;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .SCREEN_W(96), .SCREEN_H(64), .SPRITE_W(21), .SPRITE_H(18),
    .FRAMES_PER_STEP(FPS), .INIT_X(37), .INIT_Y(23)
  ) dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .leftX(leftX), .topY(topY), .auto_mode(auto_mode), .hit_edge(hit_edge)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: plain signed integers, directions as +1/-1.
  int m_x, m_y, m_cnt, m_dx, m_dy;
  bit m_auto, m_hit, m_cprev;

  function automatic void model_clock();
    bit rise;
    int nx, ny, rx, ry;
    if (reset) begin
      m_x = 37; m_y = 23; m_auto = 0; m_hit = 0; m_cnt = 0;
      m_dx = 1; m_dy = 1; m_cprev = 0;
      return;
    end
    rise    = btnC && !m_cprev;
    m_cprev = btnC;
    m_hit   = 0;
    if (rise) begin
      m_auto = !m_auto;
      m_cnt  = 0;
      if (m_auto) begin m_dx = 1; m_dy = 1; end
    end else if (frame_begin) begin
      m_cnt++;
      if (m_cnt == FPS) begin
        m_cnt = 0;
        if (!m_auto) begin
          rx = int'(btnR) - int'(btnL);
          ry = int'(btnD) - int'(btnU);
          nx = m_x + rx;
          ny = m_y + ry;
          if (nx < 0 || nx > XMAX) begin
            m_hit = 1;
`ifdef SPRITE_WRAP_AROUND_EN
            nx = (nx < 0) ? XMAX : 0;
`else
            nx = m_x;
`endif
          end
          if (ny < 0 || ny > YMAX) begin
            m_hit = 1;
`ifdef SPRITE_WRAP_AROUND_EN
            ny = (ny < 0) ? YMAX : 0;
`else
            ny = m_y;
`endif
          end
        end else begin
          nx = m_x + m_dx;
          ny = m_y + m_dy;
          if (nx < 0 || nx > XMAX) begin m_dx = -m_dx; nx = m_x + m_dx; m_hit = 1; end
          if (ny < 0 || ny > YMAX) begin m_dy = -m_dy; ny = m_y + m_dy; m_hit = 1; end
        end
        m_x = nx;
        m_y = ny;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_state(input string name, input int x, input int y, input int a, input int h);
    n_total++;
    if (int'(leftX) == x && int'(topY) == y && int'(auto_mode) == a && int'(hit_edge) == h)
      n_pass++;
    else
      $display("FAIL %s: got x=%0d y=%0d auto=%0d hit=%0d expected x=%0d y=%0d auto=%0d hit=%0d",
               name, leftX, topY, auto_mode, hit_edge, x, y, a, h);
  endtask

  task automatic tick(input string name);
    model_clock();
    @(posedge clk);
    #1;
    chk_state(name, m_x, m_y, int'(m_auto), int'(m_hit));
  endtask

  task automatic pulse(input string name);
    frame_begin = 1'b1; tick(name);
    frame_begin = 1'b0; tick(name);
  endtask

  task automatic do_step(input string name);
    pulse(name);
    pulse(name);
  endtask

  task automatic move_to(input int tx, input int ty);
    for (int i = 0; i < 200 && (m_x != tx || m_y != ty); i++) begin
      btnR = (tx > m_x); btnL = (tx < m_x);
      btnD = (ty > m_y); btnU = (ty < m_y);
      do_step("move_to");
    end
    btnR = 0; btnL = 0; btnU = 0; btnD = 0;
    chk("move_to_reached", int'(leftX) * 100 + int'(topY), tx * 100 + ty);
  endtask

  typedef struct {
    bit rst, fb, u, d, l, r, c;
    int x, y, a, h;
  } vec_t;

  vec_t tbl[15];
  int   hits;

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0, 37,23,0,0};
    tbl[1]  = '{0,1,0,0,0,1,0, 37,23,0,0};
    tbl[2]  = '{0,0,0,0,0,1,0, 37,23,0,0};
    tbl[3]  = '{0,1,0,0,0,1,0, 38,23,0,0};
    tbl[4]  = '{0,0,0,0,0,1,0, 38,23,0,0};
    tbl[5]  = '{0,1,1,1,1,0,0, 38,23,0,0};
    tbl[6]  = '{0,1,1,1,1,0,0, 37,23,0,0};
    tbl[7]  = '{0,0,0,0,0,0,1, 37,23,1,0};
    tbl[8]  = '{0,1,0,0,0,0,1, 37,23,1,0};
    tbl[9]  = '{0,1,0,0,0,0,0, 38,24,1,0};
    tbl[10] = '{0,1,0,0,0,0,1, 38,24,0,0};
    tbl[11] = '{0,1,0,0,0,0,1, 38,24,0,0};
    tbl[12] = '{0,1,1,0,0,0,0, 38,23,0,0};
    tbl[13] = '{0,1,0,1,1,1,0, 38,23,0,0};
    tbl[14] = '{0,1,0,1,1,1,0, 38,24,0,0};

    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; frame_begin = tbl[i].fb;
      btnU = tbl[i].u; btnD = tbl[i].d; btnL = tbl[i].l; btnR = tbl[i].r; btnC = tbl[i].c;
      model_clock();
      @(posedge clk);
      #1;
      chk_state($sformatf("table[%0d]", i), tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].h);
    end
    frame_begin = 0; btnU = 0; btnD = 0; btnL = 0; btnR = 0; btnC = 0;

    // Ten pulses with btnR held from reset -> five steps.
    reset = 1; tick("reset");
    reset = 0;
    chk_state("reset_state", 37, 23, 0, 0);
    btnR = 1;
    for (int i = 0; i < 10; i++) pulse("btnR_pulses");
    btnR = 0;
    chk("pulse10_x", int'(leftX), 42);

    // Right edge: clamp (or wrap) with a single-cycle hit pulse.
    move_to(XMAX, 23);
    btnR = 1;
    pulse("edge_pre");
    frame_begin = 1; tick("edge_step");
`ifdef SPRITE_WRAP_AROUND_EN
    chk("edge_x", int'(leftX), 0);
`else
    chk("edge_x", int'(leftX), 75);
`endif
    chk("edge_hit", int'(hit_edge), 1);
    frame_begin = 0; tick("edge_after");
    chk("edge_hit_clear", int'(hit_edge), 0);
    btnR = 0;

    // AUTO bounce off the bottom-right corner.
    move_to(74, 45);
    btnC = 1; tick("to_auto");
    btnC = 0; tick("to_auto_rel");
    chk("auto_on", int'(auto_mode), 1);
    do_step("auto_a");
    chk("auto_corner", int'(leftX) * 100 + int'(topY), 7546);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      frame_begin = (i % 2 == 0);
      tick("auto_bounce");
      if (hit_edge) hits++;
    end
    frame_begin = 0;
    chk("bounce_pos", int'(leftX) * 100 + int'(topY), 7445);
    chk("bounce_hits", hits, 1);
    do_step("auto_b");
    chk("bounce_dir", int'(leftX) * 100 + int'(topY), 7344);

    // Toggle on a step edge: no move, counter cleared.
    btnR = 1;
    frame_begin = 1; tick("tog_pre");
    btnC = 1; tick("tog_step");
    chk_state("tog_step_state", 73, 44, 0, 0);
    tick("tog_cnt1");
    chk("tog_cnt_cleared", int'(leftX), 73);
    btnC = 0; tick("tog_cnt2");
    chk("tog_first_step", int'(leftX), 74);
    frame_begin = 0; btnR = 0;

    // Reset in the middle of AUTO.
    btnC = 1; tick("auto2");
    btnC = 0; tick("auto2_rel");
    do_step("auto2_move");
    frame_begin = 1; reset = 1; tick("mid_reset");
    chk_state("mid_reset_state", 37, 23, 0, 0);
    reset = 0; frame_begin = 0;

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 499) == 0);
      frame_begin = ($urandom_range(0, 2) == 0);
      btnU = 1'($urandom_range(0, 1));
      btnD = 1'($urandom_range(0, 1));
      btnL = 1'($urandom_range(0, 1));
      btnR = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) btnC = ~btnC;
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
